// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO (async_fifo) and its storage array.
package async_fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH      = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Memory address width; pointers carry one extra wrap bit on top of this.
  function automatic int unsigned calc_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one synchronous read port.
// The read register is reset so the FIFO output starts at zero; the array itself is not.
module fifo_mem #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_W     = 2
) (
  input  logic                  wr_clk,
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with full/empty flags and registered read data. wr_clk and rd_clk
// must come from the same net; the split names keep it pin-compatible with the dual-clock part.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned ADDR_W = calc_addr_w(DEPTH);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            wr_accept;
  logic            rd_accept;

  // Same low bits with differing wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst)            wr_ptr <= '0;
    else if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst)            rd_ptr <= '0;
    else if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .wr_clk  (wr_clk),
    .rd_clk  (rd_clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo (DEPTH=4, DATA_WIDTH=8) with a queue scoreboard.
module tb_async_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       rd_en;
  logic       full;
  logic       empty;
  logic [7:0] rd_data;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_rd;

  always #5 clk = ~clk;

  async_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .wr_clk  (clk),
    .rd_clk  (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .full    (full),
    .empty   (empty),
    .rd_data (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
    check({tag, ".empty"},   32'(empty),   32'(sb.size() == 0));
    check({tag, ".full"},    32'(full),    32'(sb.size() == DEPTH));
  endtask

  // One clock cycle: drive at the falling edge, update the model at the rising edge, sample 1 ns later.
  task automatic step(input string tag, input logic we, input logic re, input logic [7:0] d);
    bit wa, ra;
    @(negedge clk);
    wr_en = we; rd_en = re; wr_data = d;
    @(posedge clk);
    wa = we && (sb.size() < DEPTH);
    ra = re && (sb.size() > 0);
    if (ra) exp_rd = sb.pop_front();
    if (wa) sb.push_back(d);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    exp_rd = 8'h00;
    #15;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill, then a non-write cycle with 5 on the bus.
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, 1'b0, 8'(i));
    step("fill_idle", 1'b0, 1'b0, 8'd5);

    // Drain and hold.
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 8'h00);
    step("drain_hold", 1'b0, 1'b0, 8'h00);

    // Overflow while full, underflow while empty.
    for (int i = 1; i <= 4; i++) step("refill", 1'b1, 1'b0, 8'(i));
    step("overflow", 1'b1, 1'b0, 8'd9);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, 1'b1, 8'h00);
    step("underflow", 1'b0, 1'b1, 8'h00);
    step("underflow2", 1'b0, 1'b1, 8'h00);

    // Simultaneous read and write while empty: only the write lands, no bypass.
    step("rw_empty", 1'b1, 1'b1, 8'h33);
    step("rw_empty_pop", 1'b0, 1'b1, 8'h00);

    // Two entries resident, six concurrent read/write cycles across the wrap.
    step("sim_pre", 1'b1, 1'b0, 8'h10);
    step("sim_pre", 1'b1, 1'b0, 8'h11);
    for (int i = 0; i < 6; i++) step("sim", 1'b1, 1'b1, 8'(8'h20 + i));
    step("sim_post", 1'b0, 1'b1, 8'h00);
    step("sim_post", 1'b0, 1'b1, 8'h00);

    // Full with both requests: only the read is taken, leaving three entries.
    for (int i = 0; i < 4; i++) step("fill3", 1'b1, 1'b0, 8'(8'h40 + i));
    step("full_rw", 1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 3; i++) step("full_rw_drain", 1'b0, 1'b1, 8'h00);
    step("full_rw_under", 1'b0, 1'b1, 8'h00);

    // Asynchronous reset mid-operation, then normal use afterwards.
    step("pre_rst", 1'b1, 1'b0, 8'hA1);
    step("pre_rst", 1'b1, 1'b1, 8'hA2);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #2;
    rst = 1'b1;
    sb.delete();
    exp_rd = 8'h00;
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_wr", 1'b1, 1'b0, 8'h5A);
    step("post_rst_rd", 1'b0, 1'b1, 8'h00);
    step("post_rst_hold", 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
